// File: rtl/alu_pipe.sv
// alu_pipe: one-deep result-registered ALU with a valid/ready handshake on both sides.
// Build with ALU_PIPE_MUL_EN defined to add an iterative shift-add multiplier (opsel 6'b001000).
`timescale 1ns/1ps
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opsel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             busy
);
    localparam int HW = WIDTH / 2;

    logic signed [WIDTH-1:0] sa, sb;
    logic                    eq, lt, az, an;
    logic                    cmp;
    logic [WIDTH-1:0]        res;
    logic                    accept;

    assign sa = a;
    assign sb = b;
    assign eq = (a == b);
    assign lt = (sa < sb);
    assign az = (a == '0);
    assign an = a[WIDTH-1];

    always_comb begin
        cmp = 1'b0;
        case (opsel[3:0])
            4'd1:    cmp = eq;
            4'd2:    cmp = lt;
            4'd3:    cmp = lt | eq;
            4'd5:    cmp = az;
            4'd6:    cmp = an;
            4'd7:    cmp = an | az;
            4'd8:    cmp = 1'b1;
            4'd9:    cmp = !eq;
            4'd10:   cmp = !lt;
            4'd11:   cmp = !(lt | eq);
            4'd13:   cmp = !az;
            4'd14:   cmp = !an;
            4'd15:   cmp = !(an | az);
            default: cmp = 1'b0;
        endcase
    end

    // Compare group outranks address calc when opsel[5] and opsel[4] are both set.
    always_comb begin
        res = '0;
        if (opsel[4]) begin
            res = {{(WIDTH-1){1'b0}}, cmp};
        end else if (opsel[5]) begin
            res = a + (b << 2);
        end else begin
            case (opsel[3:0])
                4'd0:    res = a + b;
                4'd1:    res = a - b;
                4'd4:    res = a & b;
                4'd5:    res = a | b;
                4'd6:    res = a ^ b;
                4'd11:   res = {b[HW-1:0], {HW{1'b0}}};
                4'd12:   res = ~(a & b);
                4'd13:   res = ~(a | b);
                4'd14:   res = ~(a ^ b);
                default: res = '0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, MUL} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand, mplier, acc, acc_nxt;
    logic [CW-1:0]    cnt;
    logic             is_mul;

    assign is_mul   = (opsel == 6'b001000);
    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign busy     = (state == MUL);
    assign acc_nxt  = acc + (mplier[0] ? mcand : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            if (out_valid && out_ready)
                out_valid <= 1'b0;
            if (state == MUL) begin
                acc    <= acc_nxt;
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == LAST) begin
                    out       <= acc_nxt;
                    out_valid <= 1'b1;
                    state     <= IDLE;
                end
            end else if (accept) begin
                if (is_mul) begin
                    state  <= MUL;
                    mcand  <= a;
                    mplier <= b;
                    acc    <= '0;
                    cnt    <= '0;
                end else begin
                    out       <= res;
                    out_valid <= 1'b1;
                end
            end
        end
    end
`else
    assign in_ready = !out_valid || out_ready;
    assign busy     = 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (accept) begin
            out       <= res;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule
